// File: rtl/cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter
//
// Shares one cacheline-wide physical memory port between the I-cache and the
// D-cache. One transaction is in flight at a time. The grant is registered, so
// there is always one idle turnaround cycle between transactions. The response
// and read data are returned to the granted requester only.
//
// Optional feature macro: CACHE_ARB_RR_EN
//   defined   : round-robin tie-break using a 1-bit last-granted pointer
//   undefined : fixed priority, the D-cache wins every tie
//
// Ports
//   clk, rst                  clock (rising edge), async active-low reset
//   i_read, i_address         I-cache line read request (held until i_resp)
//   i_resp, i_rdata           I-cache completion pulse and read line
//   d_read, d_write           D-cache line read / write request (held until d_resp)
//   d_address, d_wdata        D-cache line address and write line
//   d_resp, d_rdata           D-cache completion pulse and read line
//   mem_read, mem_write       downstream request
//   mem_address, mem_wdata    downstream address and write line
//   mem_rdata, mem_resp       downstream read line and completion
//
// Handshake: a requester raises its request and holds it, together with its
// address/data, until it sees its resp pulse. Downstream, mem_read/mem_write
// stay asserted with stable address/data until mem_resp is seen; the resp to
// the requester is issued combinationally in that same cycle.
// -----------------------------------------------------------------------------
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic d_req;
    logic tie_pick_d;   // 1: D wins a simultaneous request
    logic d_wr_q;       // D operation type captured at grant

    assign d_req = d_read | d_write;

    // Read data is broadcast; only the matching resp qualifies it.
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

`ifdef CACHE_ARB_RR_EN
    // last_d = 1 when the most recent grant went to D. Reset value of 0 means
    // "last was I", so D wins the first tie.
    logic last_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_d <= 1'b0;
        end else if (state == IDLE && state_next != IDLE) begin
            last_d <= (state_next == SERVE_D);
        end
    end

    assign tie_pick_d = ~last_d;
`else
    assign tie_pick_d = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Remember whether the granted D transaction was a write, so the
    // downstream request stays asserted even if the D-cache drops its
    // request before mem_resp.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_wr_q <= 1'b0;
        end else if (state == IDLE && state_next == SERVE_D) begin
            d_wr_q <= d_write;
        end
    end

    // Next state and outputs
    always_comb begin
        state_next  = state;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        i_resp      = 1'b0;
        d_resp      = 1'b0;

        unique case (state)
            IDLE: begin
                // mem_resp is ignored here; nothing is in flight.
                if (i_read && d_req) begin
                    state_next = tie_pick_d ? SERVE_D : SERVE_I;
                end else if (d_req) begin
                    state_next = SERVE_D;
                end else if (i_read) begin
                    state_next = SERVE_I;
                end
            end

            SERVE_I: begin
                mem_read    = 1'b1;
                mem_address = i_address;
                if (mem_resp) begin
                    i_resp     = 1'b1;
                    state_next = IDLE;
                end
            end

            SERVE_D: begin
                // A simultaneous read+write is treated as a write.
                if (d_req) begin
                    mem_read  = d_read & ~d_write;
                    mem_write = d_write;
                end else begin
                    mem_read  = ~d_wr_q;
                    mem_write = d_wr_q;
                end
                mem_address = d_address;
                mem_wdata   = d_wdata;
                if (mem_resp) begin
                    d_resp     = 1'b1;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_mem_arbiter
//
// Directed testbench for cache_mem_arbiter. Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge. Each scenario task carries its
// own hand-computed expectations. Build with +define+CACHE_ARB_RR_EN to check
// the round-robin tie order instead of fixed D priority.
// -----------------------------------------------------------------------------
module tb_cache_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic              clk;
    logic              rst;
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic              i_resp;
    logic [LINE_W-1:0] i_rdata;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic              d_resp;
    logic [LINE_W-1:0] d_rdata;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;

    int checks;
    int passed;

    logic [LINE_W-1:0] pat_a;
    logic [LINE_W-1:0] pat_b;
    logic [LINE_W-1:0] pat_c;

    cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_resp(d_resp), .d_rdata(d_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        i_read    = 1'b0;
        i_address = '0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        d_address = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_resp  = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        #2 rst = 1'b0;
        idle_inputs();
        next_cycle();
        next_cycle();
        #2 rst = 1'b1;
        next_cycle();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        // Bring up, then start a D write and pull reset in the middle of it.
        idle_inputs();
        rst = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++;
        if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0 || mem_address !== '0 || mem_wdata !== '0)
            $display("FAIL reset_outputs: rd=%b wr=%b iresp=%b dresp=%b addr=%h expected all 0",
                     mem_read, mem_write, i_resp, d_resp, mem_address);
        else passed++;

        #2 rst = 1'b1;
        next_cycle();
        d_write   = 1'b1;
        d_address = 32'h8000_0040;
        d_wdata   = pat_b;
        next_cycle();                       // now SERVE_D
        @(negedge clk);
        checks++;
        if (mem_write !== 1'b1) $display("FAIL reset_pre_write: mem_write=%b expected 1", mem_write);
        else passed++;

        #1 mem_resp = 1'b1;
        #1;
        checks++;
        if (d_resp !== 1'b1) $display("FAIL reset_pre_resp: d_resp=%b expected 1", d_resp);
        else passed++;

        rst = 1'b0;                         // asynchronous, mid-cycle
        #1;
        checks++;
        if (mem_write !== 1'b0 || d_resp !== 1'b0 || mem_address !== '0)
            $display("FAIL reset_async: mem_write=%b d_resp=%b addr=%h expected 0/0/0",
                     mem_write, d_resp, mem_address);
        else passed++;

        idle_inputs();
        @(posedge clk);
        #3 rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0 || mem_address !== '0 || mem_wdata !== '0)
            $display("FAIL reset_release: rd=%b wr=%b iresp=%b dresp=%b addr=%h expected all 0",
                     mem_read, mem_write, i_resp, d_resp, mem_address);
        else passed++;
        next_cycle();
    endtask

    task automatic test_i_read();
        // i_read in cycle 0; mem_read high in cycles 1..6; mem_resp in cycle 6.
        i_read    = 1'b1;
        i_address = 32'h0000_1040;
        for (int k = 1; k <= 6; k++) begin
            next_cycle();
            if (k == 6) begin
                mem_resp  = 1'b1;
                mem_rdata = pat_a;
            end
            @(negedge clk);
            checks++;
            if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 32'h0000_1040)
                $display("FAIL i_read_req c%0d: rd=%b wr=%b addr=%h expected 1/0/00001040",
                         k, mem_read, mem_write, mem_address);
            else passed++;
            checks++;
            if (i_resp !== (k == 6) || d_resp !== 1'b0)
                $display("FAIL i_read_resp c%0d: i_resp=%b d_resp=%b expected %0d/0",
                         k, i_resp, d_resp, (k == 6));
            else passed++;
        end
        checks++;
        if (i_rdata !== pat_a) $display("FAIL i_read_data: i_rdata=%h expected %h", i_rdata, pat_a);
        else passed++;

        next_cycle();
        i_read   = 1'b0;
        mem_resp = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b0 || i_resp !== 1'b0)
            $display("FAIL i_read_idle: mem_read=%b i_resp=%b expected 0/0", mem_read, i_resp);
        else passed++;
        next_cycle();
    endtask

    task automatic test_d_write();
        d_write   = 1'b1;
        d_address = 32'h8000_0020;
        d_wdata   = pat_b;
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            if (k == 3) mem_resp = 1'b1;
            @(negedge clk);
            checks++;
            if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 32'h8000_0020 || mem_wdata !== pat_b)
                $display("FAIL d_write_req c%0d: wr=%b rd=%b addr=%h expected 1/0/80000020, wdata_ok=%b",
                         k, mem_write, mem_read, mem_address, (mem_wdata === pat_b));
            else passed++;
            checks++;
            if (d_resp !== (k == 3) || i_resp !== 1'b0)
                $display("FAIL d_write_resp c%0d: d_resp=%b i_resp=%b expected %0d/0",
                         k, d_resp, i_resp, (k == 3));
            else passed++;
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (mem_write !== 1'b0 || mem_wdata !== '0)
            $display("FAIL d_write_idle: mem_write=%b wdata_zero=%b expected 0/1", mem_write, (mem_wdata === '0));
        else passed++;
        next_cycle();
    endtask

    task automatic test_tie();
        // Both requesters held continuously; zero-latency memory.
        logic [3:0] exp_d;   // bit t: 1 = D expected to win grant t
`ifdef CACHE_ARB_RR_EN
        exp_d = 4'b0101;     // D, I, D, I
`else
        exp_d = 4'b1111;     // D every time
`endif
        apply_reset();
        i_read    = 1'b1;
        i_address = 32'h0000_0100;
        d_read    = 1'b1;
        d_address = 32'h0000_0200;
        for (int t = 0; t < 4; t++) begin
            next_cycle();               // SERVE for grant t
            mem_resp  = 1'b1;
            mem_rdata = pat_c;
            @(negedge clk);
            checks++;
            if (mem_read !== 1'b1 || mem_address !== (exp_d[t] ? 32'h0000_0200 : 32'h0000_0100))
                $display("FAIL tie_grant%0d: rd=%b addr=%h expected 1/%h", t, mem_read, mem_address,
                         (exp_d[t] ? 32'h0000_0200 : 32'h0000_0100));
            else passed++;
            checks++;
            if (d_resp !== exp_d[t] || i_resp !== ~exp_d[t])
                $display("FAIL tie_resp%0d: d_resp=%b i_resp=%b expected %b/%b", t, d_resp, i_resp,
                         exp_d[t], ~exp_d[t]);
            else passed++;
            next_cycle();               // turnaround cycle in IDLE
            mem_resp = 1'b0;
            @(negedge clk);
            checks++;
            if (mem_read !== 1'b0 || d_resp !== 1'b0 || i_resp !== 1'b0)
                $display("FAIL tie_turn%0d: rd=%b d_resp=%b i_resp=%b expected 0/0/0", t, mem_read, d_resp, i_resp);
            else passed++;
        end
        idle_inputs();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_mid_arrival();
        d_read    = 1'b1;
        d_address = 32'h0000_3000;
        next_cycle();                   // SERVE_D cycle 1
        i_read    = 1'b1;
        i_address = 32'h0000_4000;
        for (int k = 1; k <= 3; k++) begin
            if (k == 3) begin
                mem_resp  = 1'b1;
                mem_rdata = pat_a;
            end
            @(negedge clk);
            checks++;
            if (mem_address !== 32'h0000_3000 || i_resp !== 1'b0 || d_resp !== (k == 3))
                $display("FAIL mid_serve_d c%0d: addr=%h i_resp=%b d_resp=%b expected 00003000/0/%0d",
                         k, mem_address, i_resp, d_resp, (k == 3));
            else passed++;
            next_cycle();
        end
        d_read   = 1'b0;                // M+1: IDLE, I grant taken here
        mem_resp = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b0 || i_resp !== 1'b0)
            $display("FAIL mid_turn: mem_read=%b i_resp=%b expected 0/0", mem_read, i_resp);
        else passed++;
        next_cycle();                   // M+2: SERVE_I
        mem_resp  = 1'b1;
        mem_rdata = pat_c;
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b1 || mem_address !== 32'h0000_4000 || i_resp !== 1'b1 || i_rdata !== pat_c)
            $display("FAIL mid_serve_i: rd=%b addr=%h i_resp=%b expected 1/00004000/1", mem_read, mem_address, i_resp);
        else passed++;
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_spurious_resp();
        mem_resp  = 1'b1;
        mem_rdata = pat_b;
        @(negedge clk);
        checks++;
        if (i_resp !== 1'b0 || d_resp !== 1'b0 || mem_read !== 1'b0)
            $display("FAIL spurious_resp: i_resp=%b d_resp=%b rd=%b expected 0/0/0", i_resp, d_resp, mem_read);
        else passed++;
        next_cycle();
        mem_resp = 1'b0;
        d_read    = 1'b1;
        d_address = 32'h0000_5000;
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b0) $display("FAIL spurious_still_idle: mem_read=%b expected 0", mem_read);
        else passed++;
        next_cycle();                   // one-cycle grant latency proves IDLE
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b1 || mem_address !== 32'h0000_5000)
            $display("FAIL spurious_grant: rd=%b addr=%h expected 1/00005000", mem_read, mem_address);
        else passed++;
        mem_resp = 1'b1;
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0;
        passed = 0;
        pat_a  = {8{32'hA5A5_0001}};
        pat_b  = {8{32'h5A5A_0002}};
        pat_c  = {8{32'h0F0F_0003}};
        rst    = 1'b0;
        idle_inputs();

        test_reset();
        test_i_read();
        test_d_write();
        test_mid_arrival();
        test_spurious_resp();
        test_tie();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
